eth_cfg_arb: RTL and testbench
==============================

// Module: eth_cfg_arb
// PURPOSE
//  Round-robin arbiter and sequencer for the eth_wrap register interface (usr_cfg_type/usr_wr_*/usr_rd_*).
//  Shares the single cfg port between NUM_REQ requesters, e.g. the VIO test path and an init/link-monitor engine.
//  Issues one access at a time, gated by eth_init_done. Returns write acks, read data and read timeouts per requester.
//  Sits in the clk_125m (s_axi_aclk) domain, between the cfg requesters and eth_wrap.
// PARAMETERS
//  NUM_REQ         2     number of requesters (1..8)
//  REG_ADDR_WIDTH  32    register address width
//  REG_DATA_WIDTH  32    register data width
//  RD_TIMEOUT      1024  cycles to wait for usr_rd_vld before flagging an error (>=2)
//  WR_GAP          2     idle cycles enforced after each write before the next grant (>=0)
// PORTS
//  clk            in   1                  clock (clk_125m domain)
//  rst            in   1                  synchronous reset, active-high
//  eth_init_done  in   1                  no grant issued while low
//  req_vld        in   NUM_REQ            per-requester request pending; hold until req_rdy
//  req_wr         in   NUM_REQ            1=write, 0=read
//  req_cfg_type   in   NUM_REQ            forwarded to usr_cfg_type
//  req_addr       in   NUM_REQ*AW         flattened; requester i at [i*AW +: AW]
//  req_wdata      in   NUM_REQ*DW         flattened write data
//  req_rdy        out  NUM_REQ            one-hot accept pulse
//  rsp_vld        out  NUM_REQ            one-hot completion pulse
//  rsp_err        out  1                  valid with rsp_vld; 1 = read timeout
//  rsp_rdata      out  DW                 valid with rsp_vld; read data (0 for writes and timeouts)
//  usr_cfg_type   out  1                  to eth_wrap
//  usr_wr_en      out  1                  to eth_wrap
//  usr_wr_addr    out  AW                 to eth_wrap
//  usr_wr_data    out  DW                 to eth_wrap
//  usr_rd_en      out  1                  to eth_wrap
//  usr_rd_addr    out  AW                 to eth_wrap
//  usr_rd_vld     in   1                  from eth_wrap
//  usr_rd_data    in   DW                 from eth_wrap
//  timeout_cnt    out  16                 saturating read-timeout count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: every output 0; FSM=IDLE; RR pointer=0; in-flight access dropped with no rsp_vld.
//  - FSM states: IDLE, ISSUE, WAIT_RD, GAP.
//  - IDLE -> ISSUE, at cycle T, when eth_init_done=1 and any req_vld:
//    * Winner is the first set req_vld at or after ptr, scanning upward with wrap.
//    * req_rdy[win]=1 at T (combinational, one cycle); type/addr/wdata/wr latched at T.
//    * ptr <= win+1, wrapping NUM_REQ-1 -> 0.
//  - ISSUE (T+1): registered usr_wr_en or usr_rd_en high for exactly one cycle.
//    * usr_*_addr, usr_wr_data and usr_cfg_type hold their latched values until the next grant.
//  - Write: rsp_vld[win]=1 with rsp_err=0 and rsp_rdata=0 at T+2.
//    * Then GAP for WR_GAP cycles, then IDLE; if WR_GAP=0, straight to IDLE.
//    * Earliest next req_rdy is at T+2+WR_GAP.
//  - Read: WAIT_RD from T+2; the counter starts at 0 and increments each cycle.
//    * usr_rd_vld=1 at cycle C: rsp_rdata<=usr_rd_data, rsp_err=0, rsp_vld at C+1, then IDLE.
//    * usr_rd_vld sampled at T+1 (the ISSUE cycle) is also accepted.
//    * Counter reaches RD_TIMEOUT-1 with no usr_rd_vld: rsp_vld with rsp_err=1 and rsp_rdata=0, then IDLE.
//    * If usr_rd_vld and timeout land on the same cycle, the data wins (err=0).
//  - usr_rd_vld outside ISSUE/WAIT_RD, including late data after a timeout, is ignored.
//  - eth_init_done falling mid-access does not abort the access; it only blocks new grants.
//  - req_vld dropped before req_rdy: no grant; the pointer does not move.
//  - Never more than one access outstanding; usr_wr_en and usr_rd_en are never both high.
// CONFIGURATION
//  ETH_CFG_ARB_STATS_EN defined:
//    timeout_cnt increments by 1 on each timeout rsp; saturates at 16'hFFFF; cleared only by rst.
//  ETH_CFG_ARB_STATS_EN undefined:
//    timeout_cnt tied to 16'd0; no counter logic.
// TESTING
//  1) eth_init_done=0, req_vld=2'b01 -> no req_rdy for 50 cycles.
//     Raise init_done -> req_rdy[0] the same cycle, usr_wr_en one cycle later.
//  2) Write from req0: addr=0x0000_0004, data=0x1234_5678, cfg_type=1.
//     -> usr_wr_en=1 with those values at T+1; rsp_vld[0]=1, rsp_err=0 at T+2; next grant no earlier than T+4.
//  3) Read from req1: addr 0x10; bench returns usr_rd_vld with 0xCAFE_F00D 5 cycles after usr_rd_en.
//     -> rsp_vld[1]=1, rsp_rdata=0xCAFE_F00D one cycle later.
//  4) Read with no usr_rd_vld, RD_TIMEOUT=16:
//     -> rsp_err=1 and rsp_rdata=0 after 16 WAIT_RD cycles.
//     -> timeout_cnt=1 with STATS_EN, 0 without; a late usr_rd_vld produces no rsp_vld.
//  5) req_vld=2'b11 held continuously with writes:
//     -> grants alternate 0,1,0,1 for 8 grants; no requester is granted twice in a row.
//  6) rst asserted during WAIT_RD:
//     -> all outputs 0 the next cycle; no rsp_vld; first grant after rst goes to req0.

Source files
------------

// File: rtl/eth_cfg_arb_if.sv
// Requester-side bus of eth_cfg_arb: per-requester request fields, one-hot accept and completion strobes.
interface eth_cfg_arb_if #(
    parameter int NUM_REQ        = 2,
    parameter int REG_ADDR_WIDTH = 32,
    parameter int REG_DATA_WIDTH = 32
);
    // Handshake: a requester raises req_vld[i] with its fields stable and holds them until
    // req_rdy[i] pulses for one cycle; the transfer happens in that cycle. Dropping req_vld
    // earlier withdraws the request. rsp_vld[i] pulses once per accepted request, with
    // rsp_err/rsp_rdata valid only in that cycle; there is no backpressure on responses.
    logic [NUM_REQ-1:0]                req_vld;
    logic [NUM_REQ-1:0]                req_wr;
    logic [NUM_REQ-1:0]                req_cfg_type;
    logic [NUM_REQ*REG_ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*REG_DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]                req_rdy;
    logic [NUM_REQ-1:0]                rsp_vld;
    logic                              rsp_err;
    logic [REG_DATA_WIDTH-1:0]         rsp_rdata;

    modport master (
        output req_vld, req_wr, req_cfg_type, req_addr, req_wdata,
        input  req_rdy, rsp_vld, rsp_err, rsp_rdata
    );

    modport slave (
        input  req_vld, req_wr, req_cfg_type, req_addr, req_wdata,
        output req_rdy, rsp_vld, rsp_err, rsp_rdata
    );
endinterface

// File: rtl/eth_cfg_arb.sv
// Round-robin arbiter/sequencer sharing the eth_wrap cfg port between NUM_REQ requesters.
// Define ETH_CFG_ARB_STATS_EN to enable the saturating read-timeout counter on timeout_cnt.
module eth_cfg_arb #(
    parameter int NUM_REQ        = 2,
    parameter int REG_ADDR_WIDTH = 32,
    parameter int REG_DATA_WIDTH = 32,
    parameter int RD_TIMEOUT     = 1024,
    parameter int WR_GAP         = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      eth_init_done,
    eth_cfg_arb_if.slave              cfg,
    output logic                      usr_cfg_type,
    output logic                      usr_wr_en,
    output logic [REG_ADDR_WIDTH-1:0] usr_wr_addr,
    output logic [REG_DATA_WIDTH-1:0] usr_wr_data,
    output logic                      usr_rd_en,
    output logic [REG_ADDR_WIDTH-1:0] usr_rd_addr,
    input  logic                      usr_rd_vld,
    input  logic [REG_DATA_WIDTH-1:0] usr_rd_data,
    output logic [15:0]               timeout_cnt,
    output logic [1:0]                fsm_state
);
    localparam int AW = REG_ADDR_WIDTH;
    localparam int DW = REG_DATA_WIDTH;
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(RD_TIMEOUT);
    localparam int GW = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        GAP     = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   scan_idx;
    logic            win_found;
    logic [PW-1:0]   cur_idx;
    logic            cur_wr;
    logic [CW-1:0]   rd_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            grant;
    logic            wr_en_nxt;
    logic            rd_en_nxt;
    logic            rsp_fire;
    logic            rsp_err_nxt;
    logic            rd_take;

    logic [AW-1:0] addr_arr  [NUM_REQ];
    logic [DW-1:0] wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = cfg.req_addr[g*AW +: AW];
        assign wdata_arr[g] = cfg.req_wdata[g*DW +: DW];
    end

    // First pending requester at or after ptr, wrapping past NUM_REQ-1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = PW'((int'(ptr) + i) % NUM_REQ);
            if (!win_found && cfg.req_vld[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        cfg.req_rdy = '0;
        grant       = 1'b0;
        wr_en_nxt   = 1'b0;
        rd_en_nxt   = 1'b0;
        rsp_fire    = 1'b0;
        rsp_err_nxt = 1'b0;
        rd_take     = 1'b0;
        case (state)
            IDLE: begin
                if (!rst && eth_init_done && win_found) begin
                    grant                = 1'b1;
                    cfg.req_rdy[win_idx] = 1'b1;
                    wr_en_nxt            = cfg.req_wr[win_idx];
                    rd_en_nxt            = !cfg.req_wr[win_idx];
                    state_nxt            = ISSUE;
                end
            end
            ISSUE: begin
                if (cur_wr) begin
                    rsp_fire  = 1'b1;
                    state_nxt = (WR_GAP == 0) ? IDLE : GAP;
                end else if (usr_rd_vld) begin
                    rsp_fire  = 1'b1;
                    rd_take   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = WAIT_RD;
                end
            end
            WAIT_RD: begin
                // Data arriving on the last counted cycle beats the timeout.
                if (usr_rd_vld) begin
                    rsp_fire  = 1'b1;
                    rd_take   = 1'b1;
                    state_nxt = IDLE;
                end else if (rd_cnt == CW'(RD_TIMEOUT - 1)) begin
                    rsp_fire    = 1'b1;
                    rsp_err_nxt = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt == GW'(WR_GAP - 1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr           <= '0;
            cur_idx       <= '0;
            cur_wr        <= 1'b0;
            rd_cnt        <= '0;
            gap_cnt       <= '0;
            usr_wr_en     <= 1'b0;
            usr_rd_en     <= 1'b0;
            usr_wr_addr   <= '0;
            usr_rd_addr   <= '0;
            usr_wr_data   <= '0;
            usr_cfg_type  <= 1'b0;
            cfg.rsp_vld   <= '0;
            cfg.rsp_err   <= 1'b0;
            cfg.rsp_rdata <= '0;
        end else begin
            usr_wr_en <= wr_en_nxt;
            usr_rd_en <= rd_en_nxt;
            rd_cnt    <= (state == WAIT_RD) ? rd_cnt + 1'b1 : '0;
            gap_cnt   <= (state == GAP) ? gap_cnt + 1'b1 : '0;
            if (grant) begin
                usr_wr_addr  <= addr_arr[win_idx];
                usr_rd_addr  <= addr_arr[win_idx];
                usr_wr_data  <= wdata_arr[win_idx];
                usr_cfg_type <= cfg.req_cfg_type[win_idx];
                cur_wr       <= cfg.req_wr[win_idx];
                cur_idx      <= win_idx;
                ptr          <= (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            end
            cfg.rsp_vld <= '0;
            if (rsp_fire) cfg.rsp_vld[cur_idx] <= 1'b1;
            cfg.rsp_err   <= rsp_err_nxt;
            cfg.rsp_rdata <= rd_take ? usr_rd_data : '0;
        end
    end

`ifdef ETH_CFG_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_cnt <= '0;
        end else if (rsp_err_nxt && timeout_cnt != 16'hFFFF) begin
            timeout_cnt <= timeout_cnt + 16'd1;
        end
    end
`else
    assign timeout_cnt = 16'd0;
`endif

    assign fsm_state = state;

endmodule

// File: tb/tb_eth_cfg_arb.sv
// Self-checking bench for eth_cfg_arb: init gating, write/read/timeout sequencing, round-robin and reset.
module tb_eth_cfg_arb;
    localparam int NR  = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int RDT = 16;
    localparam int GAP = 2;
    localparam int SW  = NR + 1 + DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          eth_init_done;
    logic          usr_rd_vld;
    logic [DW-1:0] usr_rd_data;
    logic          usr_cfg_type;
    logic          usr_wr_en;
    logic          usr_rd_en;
    logic [AW-1:0] usr_wr_addr;
    logic [AW-1:0] usr_rd_addr;
    logic [DW-1:0] usr_wr_data;
    logic [15:0]   timeout_cnt;
    logic [1:0]    fsm_state;

    int total = 0;
    int bad   = 0;
    logic [SW-1:0] exp_q[$];
    logic [SW-1:0] exp_e;

    eth_cfg_arb_if #(.NUM_REQ(NR), .REG_ADDR_WIDTH(AW), .REG_DATA_WIDTH(DW)) cfg ();

    eth_cfg_arb #(
        .NUM_REQ(NR), .REG_ADDR_WIDTH(AW), .REG_DATA_WIDTH(DW),
        .RD_TIMEOUT(RDT), .WR_GAP(GAP)
    ) dut (
        .clk(clk), .rst(rst), .eth_init_done(eth_init_done), .cfg(cfg),
        .usr_cfg_type(usr_cfg_type), .usr_wr_en(usr_wr_en), .usr_wr_addr(usr_wr_addr),
        .usr_wr_data(usr_wr_data), .usr_rd_en(usr_rd_en), .usr_rd_addr(usr_rd_addr),
        .usr_rd_vld(usr_rd_vld), .usr_rd_data(usr_rd_data),
        .timeout_cnt(timeout_cnt), .fsm_state(fsm_state)
    );

    always #4 clk = ~clk;

    // Response scoreboard and access-exclusion check, sampled mid-cycle.
    always @(negedge clk) begin
        if (|cfg.rsp_vld) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected: got vld=%b err=%b rdata=%h, required no response",
                         cfg.rsp_vld, cfg.rsp_err, cfg.rsp_rdata);
            end else begin
                exp_e = exp_q.pop_front();
                if ({cfg.rsp_vld, cfg.rsp_err, cfg.rsp_rdata} !== exp_e) begin
                    bad++;
                    $display("FAIL rsp_scoreboard: got vld/err/rdata=%h, required %h",
                             {cfg.rsp_vld, cfg.rsp_err, cfg.rsp_rdata}, exp_e);
                end
            end
        end
        if (usr_wr_en || usr_rd_en) begin
            total++;
            if (usr_wr_en && usr_rd_en) begin
                bad++;
                $display("FAIL en_exclusive: got wr_en=%b rd_en=%b, required one of them", usr_wr_en, usr_rd_en);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test by 100us, required finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic ctype,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        cfg.req_wr[i]             = wr;
        cfg.req_cfg_type[i]       = ctype;
        cfg.req_addr[i*AW +: AW]  = a;
        cfg.req_wdata[i*DW +: DW] = d;
        cfg.req_vld[i]            = 1'b1;
    endtask

    task automatic wait_grant(input int max_cyc, output int idx, output int waited);
        idx    = -1;
        waited = 0;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk);
            if (|cfg.req_rdy) begin
                waited = k;
                idx    = (cfg.req_rdy == 2'b01) ? 0 : (cfg.req_rdy == 2'b10) ? 1 : -2;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst              = 1'b1;
        eth_init_done    = 1'b0;
        usr_rd_vld       = 1'b0;
        usr_rd_data      = '0;
        cfg.req_vld      = '0;
        cfg.req_wr       = '0;
        cfg.req_cfg_type = '0;
        cfg.req_addr     = '0;
        cfg.req_wdata    = '0;
        repeat (3) step();
        @(negedge clk);
        total++;
        if ({usr_wr_en, usr_rd_en, usr_cfg_type, usr_wr_addr, usr_rd_addr, usr_wr_data,
             cfg.rsp_vld, cfg.rsp_err, cfg.rsp_rdata, cfg.req_rdy, timeout_cnt, fsm_state} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got wr_en=%b rd_en=%b rsp_vld=%b req_rdy=%b state=%0d, required all 0",
                     usr_wr_en, usr_rd_en, cfg.rsp_vld, cfg.req_rdy, fsm_state);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_init_gate_and_write();
        int rdy_seen = 0;
        int idx, w;
        set_req(0, 1'b1, 1'b1, 32'h0000_0004, 32'h1234_5678);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (cfg.req_rdy !== 2'b00) rdy_seen++;
        end
        total++;
        if (rdy_seen !== 0) begin
            bad++;
            $display("FAIL init_gate: got %0d cycles with req_rdy, required 0", rdy_seen);
        end
        step();
        eth_init_done = 1'b1;
        @(negedge clk);
        total++;
        if (cfg.req_rdy !== 2'b01) begin
            bad++;
            $display("FAIL init_grant: got req_rdy=%b, required 01", cfg.req_rdy);
        end
        exp_q.push_back({2'b01, 1'b0, 32'h0});
        step();
        cfg.req_vld[0] = 1'b0;
        total++;
        if ({usr_wr_en, usr_rd_en, usr_cfg_type, usr_wr_addr, usr_wr_data} !==
            {1'b1, 1'b0, 1'b1, 32'h0000_0004, 32'h1234_5678}) begin
            bad++;
            $display("FAIL write_issue: got wr=%b rd=%b type=%b addr=%h data=%h, required 1 0 1 00000004 12345678",
                     usr_wr_en, usr_rd_en, usr_cfg_type, usr_wr_addr, usr_wr_data);
        end
        step();
        total++;
        if ({cfg.rsp_vld, cfg.rsp_err, cfg.rsp_rdata, usr_wr_en} !== {2'b01, 1'b0, 32'h0, 1'b0}) begin
            bad++;
            $display("FAIL write_rsp: got vld=%b err=%b rdata=%h wr_en=%b, required 01 0 0 0",
                     cfg.rsp_vld, cfg.rsp_err, cfg.rsp_rdata, usr_wr_en);
        end
        set_req(1, 1'b1, 1'b0, 32'h0000_0008, 32'hA5A5_0001);
        wait_grant(10, idx, w);
        total++;
        if (idx !== 1 || w !== 3) begin
            bad++;
            $display("FAIL write_gap: got grant idx=%0d at offset %0d from T+2, required idx=1 at offset 3", idx, w);
        end
        exp_q.push_back({2'b10, 1'b0, 32'h0});
        step();
        cfg.req_vld[1] = 1'b0;
        total++;
        if ({usr_wr_en, usr_cfg_type, usr_wr_addr, usr_wr_data} !== {1'b1, 1'b0, 32'h8, 32'hA5A5_0001}) begin
            bad++;
            $display("FAIL write_issue_req1: got wr=%b type=%b addr=%h data=%h, required 1 0 00000008 a5a50001",
                     usr_wr_en, usr_cfg_type, usr_wr_addr, usr_wr_data);
        end
        repeat (5) step();
    endtask

    task automatic test_read();
        int idx, w;
        int early = 0;
        set_req(1, 1'b0, 1'b0, 32'h0000_0010, 32'h0);
        wait_grant(10, idx, w);
        total++;
        if (idx !== 1) begin
            bad++;
            $display("FAIL read_grant: got idx=%0d, required 1", idx);
        end
        exp_q.push_back({2'b10, 1'b0, 32'hCAFE_F00D});
        step();
        cfg.req_vld[1] = 1'b0;
        total++;
        if ({usr_rd_en, usr_wr_en, usr_rd_addr} !== {1'b1, 1'b0, 32'h10}) begin
            bad++;
            $display("FAIL read_issue: got rd=%b wr=%b addr=%h, required 1 0 00000010", usr_rd_en, usr_wr_en, usr_rd_addr);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            if (cfg.rsp_vld !== 2'b00) early++;
        end
        usr_rd_vld  = 1'b1;
        usr_rd_data = 32'hCAFE_F00D;
        step();
        usr_rd_vld  = 1'b0;
        usr_rd_data = 32'h0;
        total++;
        if (early !== 0 || {cfg.rsp_vld, cfg.rsp_err, cfg.rsp_rdata} !== {2'b10, 1'b0, 32'hCAFE_F00D}) begin
            bad++;
            $display("FAIL read_rsp: got early=%0d vld=%b err=%b rdata=%h, required 0 10 0 cafef00d",
                     early, cfg.rsp_vld, cfg.rsp_err, cfg.rsp_rdata);
        end
        repeat (2) step();
    endtask

    task automatic test_timeout();
        int idx, w;
        int n = 1;
        int late = 0;
        logic [15:0] exp_tc;
`ifdef ETH_CFG_ARB_STATS_EN
        exp_tc = 16'd1;
`else
        exp_tc = 16'd0;
`endif
        set_req(1, 1'b0, 1'b0, 32'h0000_0020, 32'h0);
        wait_grant(10, idx, w);
        exp_q.push_back({2'b10, 1'b1, 32'h0});
        step();
        cfg.req_vld[1] = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            n++;
            if (cfg.rsp_vld !== 2'b00) break;
        end
        total++;
        if (idx !== 1 || n !== 18 || {cfg.rsp_vld, cfg.rsp_err, cfg.rsp_rdata} !== {2'b10, 1'b1, 32'h0}) begin
            bad++;
            $display("FAIL timeout_rsp: got idx=%0d at T+%0d vld=%b err=%b rdata=%h, required idx=1 at T+18 10 1 0",
                     idx, n, cfg.rsp_vld, cfg.rsp_err, cfg.rsp_rdata);
        end
        step();
        total++;
        if (timeout_cnt !== exp_tc) begin
            bad++;
            $display("FAIL timeout_cnt: got %0d, required %0d", timeout_cnt, exp_tc);
        end
        usr_rd_vld  = 1'b1;
        usr_rd_data = 32'hDEAD_BEEF;
        step();
        usr_rd_vld  = 1'b0;
        usr_rd_data = 32'h0;
        for (int k = 0; k < 5; k++) begin
            if (cfg.rsp_vld !== 2'b00) late++;
            step();
        end
        total++;
        if (late !== 0 || fsm_state !== 2'd0) begin
            bad++;
            $display("FAIL late_data: got %0d rsp cycles state=%0d, required 0 and IDLE", late, fsm_state);
        end
    endtask

    task automatic test_round_robin();
        int idx, w;
        set_req(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0011);
        set_req(1, 1'b1, 1'b1, 32'h0000_0104, 32'h0000_0022);
        for (int g = 0; g < 8; g++) begin
            exp_q.push_back((g % 2 == 0) ? {2'b01, 1'b0, 32'h0} : {2'b10, 1'b0, 32'h0});
        end
        for (int g = 0; g < 8; g++) begin
            wait_grant(10, idx, w);
            total++;
            if (idx !== (g % 2) || (g > 0 && w !== 4)) begin
                bad++;
                $display("FAIL rr_grant%0d: got idx=%0d spacing=%0d, required idx=%0d spacing=4", g, idx, w, g % 2);
            end
        end
        step();
        cfg.req_vld = 2'b00;
        repeat (6) step();
    endtask

    task automatic test_reset_mid_read();
        int idx, w;
        set_req(0, 1'b0, 1'b0, 32'h0000_0030, 32'h0);
        wait_grant(10, idx, w);
        step();
        cfg.req_vld = 2'b00;
        repeat (2) step();
        total++;
        if (idx !== 0 || fsm_state !== 2'd2) begin
            bad++;
            $display("FAIL pre_reset: got idx=%0d state=%0d, required 0 and WAIT_RD(2)", idx, fsm_state);
        end
        rst = 1'b1;
        set_req(0, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_0033);
        set_req(1, 1'b1, 1'b0, 32'h0000_0204, 32'h0000_0044);
        step();
        total++;
        if ({usr_wr_en, usr_rd_en, usr_cfg_type, usr_wr_addr, usr_rd_addr, usr_wr_data,
             cfg.rsp_vld, cfg.rsp_err, cfg.rsp_rdata, timeout_cnt, fsm_state} !== '0) begin
            bad++;
            $display("FAIL reset_mid: got wr=%b rd=%b rsp_vld=%b tcnt=%0d state=%0d, required all 0",
                     usr_wr_en, usr_rd_en, cfg.rsp_vld, timeout_cnt, fsm_state);
        end
        @(negedge clk);
        total++;
        if (cfg.req_rdy !== 2'b00) begin
            bad++;
            $display("FAIL reset_rdy: got req_rdy=%b, required 00", cfg.req_rdy);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (cfg.req_rdy !== 2'b01) begin
            bad++;
            $display("FAIL post_reset_grant: got req_rdy=%b, required 01", cfg.req_rdy);
        end
        exp_q.push_back({2'b01, 1'b0, 32'h0});
        step();
        cfg.req_vld = 2'b00;
        repeat (6) step();
    endtask

    initial begin
        test_reset();
        test_init_gate_and_write();
        test_read();
        test_timeout();
        test_round_robin();
        test_reset_mid_read();
        repeat (4) step();
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL drain: got %0d responses still expected, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
